// File: rtl/mandel_colour_pkg.sv
// Shared types, default widths and the saturating grey helper for the
// Mandelbrot depth-to-colour stage.
package mandel_colour_pkg;

    localparam int DEF_DEPTH_W     = 10;
    localparam int DEF_COLOUR_W    = 8;
    localparam int DEF_PAL_ENTRIES = 16;
    localparam int DEF_GREY_GAIN   = 20;

    typedef enum logic [1:0] {
        MODE_GREY   = 2'd0,
        MODE_CYCLIC = 2'd1,
        MODE_BANDED = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    function automatic int unsigned grey_sat(input int unsigned product,
                                             input int unsigned ceiling);
        return (product > ceiling) ? ceiling : product;
    endfunction

endpackage

// File: rtl/colour_palette_ram.sv
// Runtime-writable colour palette: one write port, one registered read-first
// read port, reset loads a grey ramp (entry i = i*17 on every channel).
module colour_palette_ram #(
    parameter int ENTRIES  = 16,
    parameter int AW       = 4,
    parameter int COLOUR_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [3*COLOUR_W-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [AW-1:0]         i_raddr,
    output logic [3*COLOUR_W-1:0] o_rdata
);

    logic [3*COLOUR_W-1:0] r_mem [ENTRIES];
    logic [3*COLOUR_W-1:0] r_rdata;

    // Both updates are non-blocking, so a same-cycle read of the entry being
    // written returns the previous contents.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_mem[i] <= {3{COLOUR_W'(i * 17)}};
            end
            r_rdata <= '0;
        end else begin
            if (i_re) begin
                r_rdata <= r_mem[i_raddr];
            end
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/depth_colour_mapper.sv
// Two-stage depth-to-RGB mapper: S1 computes index/grey from the depth, S2
// holds the palette read (or grey) and presents it to the packer.
module depth_colour_mapper
    import mandel_colour_pkg::*;
#(
    parameter int DEPTH_W     = DEF_DEPTH_W,
    parameter int COLOUR_W    = DEF_COLOUR_W,
    parameter int PAL_ENTRIES = DEF_PAL_ENTRIES,
    parameter int GREY_GAIN   = DEF_GREY_GAIN,
    parameter int PAL_AW      = $clog2(PAL_ENTRIES)
) (
    input  logic                  out_stream_aclk,
    input  logic                  periph_resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DEPTH_W-1:0]    in_depth,
    input  logic                  in_sof,
    input  logic                  in_eol,
    input  logic [DEPTH_W-1:0]    max_iter,
    input  logic [1:0]            mode,
    input  logic                  pal_we,
    input  logic [PAL_AW-1:0]     pal_addr,
    input  logic [3*COLOUR_W-1:0] pal_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COLOUR_W-1:0]   out_r,
    output logic [COLOUR_W-1:0]   out_g,
    output logic [COLOUR_W-1:0]   out_b,
    output logic                  out_sof,
    output logic                  out_eol
);

    localparam int PROD_W = DEPTH_W + 5;

    logic                  r_run;
    mode_e                 r_cfg_mode;
    logic [DEPTH_W-1:0]    r_cfg_max_iter;

    logic                  r_s1_valid;
    logic                  r_s1_sof;
    logic                  r_s1_eol;
    logic                  r_s1_use_pal;
    logic [COLOUR_W-1:0]   r_s1_grey;
    logic [PAL_AW-1:0]     r_s1_index;

    logic                  r_s2_valid;
    logic                  r_s2_sof;
    logic                  r_s2_eol;
    logic                  r_s2_use_pal;
    logic [COLOUR_W-1:0]   r_s2_grey;

    logic                  w_s2_load;
    logic                  w_s1_adv;
    logic                  w_accept;
    mode_e                 w_mode;
    logic [DEPTH_W-1:0]    w_max_iter;
    logic                  w_in_set;
    logic                  w_use_pal;
    logic [PROD_W-1:0]     w_grey_prod;
    logic [COLOUR_W-1:0]   w_grey;
    logic [COLOUR_W-1:0]   w_s1_grey;
    logic [DEPTH_W-1:0]    w_band;
    logic [PAL_AW-1:0]     w_index;
    logic [3*COLOUR_W-1:0] w_pal_rdata;
    logic [COLOUR_W-1:0]   w_chan [3];

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_load;
    assign in_ready  = r_run && w_s1_adv;
    assign w_accept  = in_valid && in_ready;

    // The sof beat already belongs to the new frame, so it uses the live config.
    assign w_mode     = in_sof ? mode_e'(mode) : r_cfg_mode;
    assign w_max_iter = in_sof ? max_iter : r_cfg_max_iter;
    assign w_in_set   = (in_depth >= w_max_iter);
    assign w_use_pal  = !w_in_set && ((w_mode == MODE_CYCLIC) || (w_mode == MODE_BANDED));

    assign w_grey_prod = PROD_W'(in_depth) * PROD_W'(GREY_GAIN);
    assign w_grey      = COLOUR_W'(grey_sat(32'(w_grey_prod), unsigned'((1 << COLOUR_W) - 1)));
    assign w_s1_grey   = (w_in_set || w_use_pal) ? '0 : w_grey;

    assign w_band  = in_depth >> 2;
    assign w_index = (w_mode == MODE_BANDED)
                   ? ((w_band > DEPTH_W'(PAL_ENTRIES - 1)) ? PAL_AW'(PAL_ENTRIES - 1) : w_band[PAL_AW-1:0])
                   : in_depth[PAL_AW-1:0];

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            r_run          <= 1'b0;
            r_cfg_mode     <= MODE_GREY;
            r_cfg_max_iter <= '1;
        end else begin
            r_run <= 1'b1;
            if (w_accept && in_sof) begin
                r_cfg_mode     <= w_mode;
                r_cfg_max_iter <= max_iter;
            end
        end
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            r_s1_valid   <= 1'b0;
            r_s1_sof     <= 1'b0;
            r_s1_eol     <= 1'b0;
            r_s1_use_pal <= 1'b0;
            r_s1_grey    <= '0;
            r_s1_index   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sof     <= in_sof;
                r_s1_eol     <= in_eol;
                r_s1_use_pal <= w_use_pal;
                r_s1_grey    <= w_s1_grey;
                r_s1_index   <= w_index;
            end
        end
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            r_s2_valid   <= 1'b0;
            r_s2_sof     <= 1'b0;
            r_s2_eol     <= 1'b0;
            r_s2_use_pal <= 1'b0;
            r_s2_grey    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sof     <= r_s1_sof;
                r_s2_eol     <= r_s1_eol;
                r_s2_use_pal <= r_s1_use_pal;
                r_s2_grey    <= r_s1_grey;
            end
        end
    end

    // The palette read register is the colour half of S2; it only moves with S2.
    colour_palette_ram #(
        .ENTRIES  (PAL_ENTRIES),
        .AW       (PAL_AW),
        .COLOUR_W (COLOUR_W)
    ) u_palette (
        .i_clk   (out_stream_aclk),
        .i_rst_n (periph_resetn),
        .i_we    (pal_we),
        .i_waddr (pal_addr),
        .i_wdata (pal_wdata),
        .i_re    (w_s2_load && r_s1_valid),
        .i_raddr (r_s1_index),
        .o_rdata (w_pal_rdata)
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign w_chan[gi] = r_s2_use_pal ? w_pal_rdata[(2-gi)*COLOUR_W +: COLOUR_W] : r_s2_grey;
    end

    assign out_valid = r_s2_valid;
    assign out_r     = w_chan[0];
    assign out_g     = w_chan[1];
    assign out_b     = w_chan[2];
    assign out_sof   = r_s2_sof;
    assign out_eol   = r_s2_eol;

endmodule

// File: tb/tb_depth_colour_mapper.sv
// Scoreboard bench for depth_colour_mapper: a behavioural colour model fills
// the expected queue on every accepted beat, a monitor checks each handshake.
module tb_depth_colour_mapper;

    localparam int DW  = 10;
    localparam int CW  = 8;
    localparam int PE  = 16;
    localparam int PAW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_depth = '0;
    logic          in_sof = 1'b0;
    logic          in_eol = 1'b0;
    logic [DW-1:0] max_iter = '1;
    logic [1:0]    mode = 2'd0;
    logic          pal_we = 1'b0;
    logic [PAW-1:0] pal_addr = '0;
    logic [23:0]   pal_wdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_r, out_g, out_b;
    logic          out_sof, out_eol;

    depth_colour_mapper dut (
        .out_stream_aclk (clk),
        .periph_resetn   (rstn),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_depth        (in_depth),
        .in_sof          (in_sof),
        .in_eol          (in_eol),
        .max_iter        (max_iter),
        .mode            (mode),
        .pal_we          (pal_we),
        .pal_addr        (pal_addr),
        .pal_wdata       (pal_wdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_r           (out_r),
        .out_g           (out_g),
        .out_b           (out_b),
        .out_sof         (out_sof),
        .out_eol         (out_eol)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;
    int eol_seen = 0;
    bit bp_en = 1'b0;

    typedef struct {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
        bit          lat;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    // Behavioural model state: palette contents and the frame's captured config.
    logic [23:0] m_pal [PE];
    int          m_mode;
    int          m_max;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < PE; i++) begin
            logic [7:0] v;
            v = 8'(i * 17);
            m_pal[i] = {v, v, v};
        end
        m_mode = 0;
        m_max  = 1023;
    endfunction

    function automatic logic [23:0] ref_colour(input int d);
        int g;
        int idx;
        logic [7:0] g8;
        if (d >= m_max) return 24'h0;
        case (m_mode)
            1: return m_pal[d % PE];
            2: begin
                idx = d / 4;
                if (idx > PE - 1) idx = PE - 1;
                return m_pal[idx];
            end
            default: begin
                g = d * 20;
                if (g > 255) g = 255;
                g8 = 8'(g);
                return {g8, g8, g8};
            end
        endcase
    endfunction

    task automatic send(input int d, input bit sof, input bit eol, input bit lat);
        int   guard;
        int   c;
        logic rdy;
        exp_t e;
        in_depth = DW'(d);
        in_sof   = sof;
        in_eol   = eol;
        in_valid = 1'b1;
        guard    = 0;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            c   = cyc;
            @(posedge clk);
            if (rdy === 1'b1) break;
            guard++;
            if (guard > 1000) begin
                check("send_timeout", 32'(guard), 32'd0);
                break;
            end
        end
        if (sof) begin
            m_mode = int'(mode);
            m_max  = int'(max_iter);
        end
        e.rgb = ref_colour(d);
        e.sof = sof;
        e.eol = eol;
        e.lat = lat;
        e.cyc = c;
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
    endtask

    task automatic pal_write(input int a, input logic [23:0] d);
        pal_addr  = PAW'(a);
        pal_wdata = d;
        pal_we    = 1'b1;
        @(posedge clk);
        #1;
        pal_we = 1'b0;
        m_pal[a] = d;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 3000) begin
            @(posedge clk);
            g++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compares each handshake against the queue, and holds the
    // previously stalled word to verify it did not change.
    logic        stall_pending = 1'b0;
    logic [25:0] stall_word;
    always @(negedge clk) begin
        exp_t e;
        if (rstn !== 1'b1) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                check("stall_stable", {5'd0, out_valid, out_sof, out_eol, out_r, out_g, out_b},
                      {5'd0, 1'b1, stall_word});
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", {out_r, out_g, out_b}, 32'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check("pix_rgb", {8'd0, out_r, out_g, out_b}, {8'd0, e.rgb});
                    check("pix_markers", {30'd0, out_sof, out_eol}, {30'd0, e.sof, e.eol});
                    if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd2);
                end
                if (out_eol === 1'b1) eol_seen++;
            end
            stall_pending = (out_valid === 1'b1) && (out_ready !== 1'b1);
            stall_word    = {out_sof, out_eol, out_r, out_g, out_b};
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d beats outstanding", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Greyscale with saturation and in-set, back to back at full rate.
        mode = 2'd0; max_iter = 10'd100; out_ready = 1'b1;
        send(0, 1, 0, 1);
        send(5, 0, 0, 1);
        send(12, 0, 0, 1);
        send(13, 0, 0, 1);
        send(100, 0, 1, 1);
        drain();

        // Cyclic palette, then a write colliding with the S2 palette read.
        pal_write(3, 24'hFF0000);
        mode = 2'd1; max_iter = 10'd1023;
        send(3, 1, 0, 1);
        send(19, 0, 0, 1);
        drain();
        send(3, 0, 0, 1);
        pal_write(3, 24'h00FF00);
        send(3, 0, 0, 1);
        drain();

        // Banded palette on the reset ramp.
        mode = 2'd2; max_iter = 10'd1023;
        send(8, 1, 0, 1);
        send(63, 0, 0, 1);
        send(1000, 0, 1, 1);
        drain();

        // Mid-frame mode change: only the next sof picks it up.
        mode = 2'd0;
        send(5, 1, 0, 1);
        mode = 2'd1;
        send(5, 0, 0, 1);
        send(6, 0, 1, 1);
        send(5, 1, 0, 1);
        drain();

        // 640-pixel line under random backpressure and input gaps.
        eol_seen = 0;
        mode = 2'($urandom_range(0, 3));
        max_iter = DW'($urandom_range(200, 1023));
        bp_en = 1'b1;
        for (int p = 0; p < 640; p++) begin
            send(int'($urandom_range(0, 1023)), p == 0, p == 639, 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        bp_en = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();
        check("eol_count", 32'(eol_seen), 32'd1);

        // Random frames with fresh palette contents and configs.
        for (int f = 0; f < 4; f++) begin
            for (int w = 0; w < 4; w++) pal_write(int'($urandom_range(0, PE - 1)), 24'($urandom));
            mode = 2'($urandom_range(0, 3));
            max_iter = (f == 2) ? DW'(0) : DW'($urandom_range(1, 1023));
            bp_en = 1'b1;
            for (int p = 0; p < 64; p++) begin
                send(int'($urandom_range(0, 1023)), p == 0, (p % 16) == 15, 0);
            end
            bp_en = 1'b0;
            @(posedge clk);
            #2 out_ready = 1'b1;
            drain();
        end

        // Reset with both stages full; nothing stale may come out afterwards.
        out_ready = 1'b0;
        mode = 2'd0; max_iter = 10'd50;
        send(10, 1, 0, 0);
        send(20, 0, 0, 0);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        check("async_rst_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
        check("async_rst_markers", {30'd0, out_sof, out_eol}, 32'd0);
        sb.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        out_ready = 1'b1;
        mode = 2'd1; max_iter = 10'd1023;
        send(7, 0, 0, 0);
        send(3, 1, 1, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/depth_colour_mapper.md
# depth_colour_mapper

Pipelined colour-mapping stage between the Mandelbrot depth calculator and the AXI-Stream pixel packer. It accepts one escape depth per pixel with frame markers over a valid/ready handshake. It converts the depth to 8-bit RGB using a per-frame mode (saturating greyscale, cyclic palette or banded palette) and forwards the result to the packer at one pixel per cycle. A small runtime-writable palette lets software recolour the image without touching the depth engine.

## Interface
- DEPTH_W, 10: escape-depth width
- COLOUR_W, 8: per-channel colour width
- PAL_ENTRIES, 16: palette entries (power of two; index width PAL_AW = log2)
- GREY_GAIN, 20: greyscale multiplier
- out_stream_aclk  in  1  sole clock
- periph_resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  depth word valid
- in_ready  out  1  stage can accept
- in_depth  in  DEPTH_W  escape depth
- in_sof  in  1  first pixel of frame
- in_eol  in  1  last pixel of line
- max_iter  in  DEPTH_W  iteration limit; depth >= max_iter is in-set
- mode  in  2  0 grey, 1 cyclic palette, 2 banded palette, 3 reserved (= grey)
- pal_we  in  1  palette write strobe
- pal_addr  in  PAL_AW  palette write index
- pal_wdata  in  3*COLOUR_W  {r,g,b}
- out_valid  out  1  colour word valid
- out_ready  in  1  packer ready
- out_r, out_g, out_b  out  COLOUR_W each  colour
- out_sof, out_eol  out  1 each  markers, aligned to colour

## Operation
- Two-register pipeline. S1 latches depth, markers and the computed index/grey value. S2 holds the palette read result (or grey) and drives outputs.
- mode and max_iter are captured into a frame config register when an in_sof beat is accepted. All pixels of that frame use the captured values; changes mid-frame take effect at the next accepted sof. Out of reset the config is mode 0, max_iter all-ones.
- In-set: depth >= cfg_max_iter gives colour 0,0,0 in every mode. max_iter = 0 blacks the whole frame.
- Grey: each channel = min(depth*GREY_GAIN, 255). The product is computed at DEPTH_W+5 bits, then saturated; no wrap.
- Cyclic: index = depth mod PAL_ENTRIES.
- Banded: index = min(depth >> 2, PAL_ENTRIES-1).
- Palette reset contents: entry i = {i*17, i*17, i*17}.
- The palette write port is independent of the stream. A write and an S1 read of the same entry in the same cycle returns the old data (read-first). The new data is visible from the next read.
- Markers and colour move in lockstep; no beat is dropped, duplicated or reordered.

## Timing
- Latency: accepted beat at edge N appears on outputs after edge N+2 when out_ready is held high.
- Throughput: 1 beat/cycle sustained.
- Stage advance: S2 loads when S2 is empty or out_ready. S1 loads when S1 is empty or S2 loads. in_ready = !S1_valid | S2_load (combinational from out_ready).
- out_valid, once high, stays high with stable data until out_ready is sampled high.
- Reset (asserted asynchronously, any time, including mid-frame): out_valid=0, in_ready=0, out_r/g/b=0, out_sof=out_eol=0, both pipeline stages empty, config to default. The palette is reinitialised. in_ready rises in the first cycle after deassertion.
- Backpressure with a full pipeline holds exactly 2 beats. in_ready drops in the same cycle out_ready drops while both stages are full.

## Structure
- Package mandel_colour_pkg: mode enum (MODE_GREY, MODE_CYCLIC, MODE_BANDED, MODE_RSVD), DEPTH_W/COLOUR_W/PAL_ENTRIES/GREY_GAIN defaults, and a saturating grey function.
- Sub-module colour_palette_ram: PAL_ENTRIES x 3*COLOUR_W, one write port, one synchronous read-first read port, asynchronous reset-to-ramp init.
- The top level holds the handshake control, config capture and index/grey arithmetic.

## Test plan
- Mode 0, max_iter 100, out_ready=1; stream depths 0, 5, 12, 13, 100. Required colours: 0, 100, 240, 255 (saturated), 0 (in-set). Outputs appear 2 cycles after acceptance, 1 per cycle.
- Mode 1, write entry 3 = 0xFF0000, then depths 3 and 19. Both outputs are r=255, g=0, b=0. A write to entry 3 in the same cycle as the depth-3 read yields the old entry.
- Mode 2; depths 8, 63, 1000 with max_iter 1023. Indices are 2, 15, 15; palette colours 34, 255, 255 grey (reset ramp).
- Backpressure: random out_ready (50%) over a 640-pixel line. No loss or duplication. out_eol appears exactly once on pixel 639, and output data is stable while stalled.
- Mid-frame change of mode from 0 to 1 without sof: colours stay grey until the next sof beat, then switch to palette.
- Assert periph_resetn low with 2 beats in flight. Outputs go to zero asynchronously. After release the first accepted beat emerges correctly with no stale beats.
